// File: rtl/gc_tag_pack.sv
// gc_tag_pack: formats timestamped hits and PPS markers into 64-bit tag words
// and buffers them in a first-word-fall-through FIFO with a valid/ready read
// side. Words lost on overflow (FIFO full or marker overwritten) are counted.
module gc_tag_pack #(
  parameter int DEPTH  = 16,
  parameter int GC_W   = 48,
  parameter int FINE_W = 15,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              tdc_refclck,
  input  logic              tdc_rstn,
  input  logic              start_gc,
  input  logic              pps_trigger,
  input  logic [GC_W-1:0]   gc_now,
  input  logic              hit_valid,
  input  logic [GC_W-1:0]   hit_gc,
  input  logic [FINE_W-1:0] hit_fine,
  output logic [63:0]       m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [AW:0]       fill,
  output logic [31:0]       drop_cnt,
  output logic              overflow
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              enter_run_s;
  logic              running_s;

  logic              pps_d_r;
  logic              pps_edge_s;
  logic [FINE_W-1:0] pps_cnt_r, pps_cnt_nxt_s, pps_cnt_inc_s;
  logic [63:0]       mark_r, mark_nxt_s;
  logic              pend_r, pend_nxt_s;
  logic              mark_drop_s;

  logic              wr_en_s;
  logic [63:0]       wr_data_s;

  logic [63:0]       mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
  logic              empty_s, full_s, rd_en_s, wr_acc_s, wr_drop_s;
  logic [63:0]       m_tdata_r, m_tdata_nxt_s;
  logic              m_tvalid_r;
  logic [AW:0]       fill_r;

  logic [1:0]        drop_inc_s;
  logic [32:0]       drop_sum_s;
  logic [31:0]       drop_cnt_r, drop_nxt_s;
  logic              overflow_r, overflow_nxt_s;

  assign running_s     = (state_r == RUN);
  assign pps_edge_s    = pps_trigger & ~pps_d_r;
  assign pps_cnt_inc_s = pps_cnt_r + FINE_W'(1);

  // Run-state next-state logic; flags the IDLE->RUN transition for clearing.
  always_comb begin
    state_nxt_s = state_r;
    enter_run_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_gc) begin
          state_nxt_s = RUN;
          enter_run_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!start_gc) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Marker capture and write arbitration: hits win, a pending marker takes
  // the first hit-free RUN cycle (possibly the PPS edge cycle itself).
  always_comb begin
    mark_nxt_s    = mark_r;
    pend_nxt_s    = pend_r;
    pps_cnt_nxt_s = pps_cnt_r;
    mark_drop_s   = 1'b0;
    wr_en_s       = 1'b0;
    wr_data_s     = 64'h0;
    if (running_s) begin
      if (pps_edge_s) begin
        mark_nxt_s    = {1'b1, gc_now, pps_cnt_inc_s};
        pps_cnt_nxt_s = pps_cnt_inc_s;
        pend_nxt_s    = 1'b1;
        mark_drop_s   = pend_r;
      end else begin
        pend_nxt_s    = pend_r;
      end
      if (hit_valid) begin
        wr_en_s   = 1'b1;
        wr_data_s = {1'b0, hit_gc, hit_fine};
      end else if (pend_nxt_s) begin
        wr_en_s    = 1'b1;
        wr_data_s  = mark_nxt_s;
        pend_nxt_s = 1'b0;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      pend_nxt_s = 1'b0;
      if (enter_run_s) begin
        pps_cnt_nxt_s = {FINE_W{1'b0}};
      end else begin
        pps_cnt_nxt_s = pps_cnt_r;
      end
    end
  end

  // FIFO pointer update and next head word; the head is registered so the
  // output is zero whenever the FIFO will be empty.
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = ((wr_ptr_r ^ rd_ptr_r) == {1'b1, {AW{1'b0}}});
    rd_en_s   = ~empty_s & m_tready;
    wr_acc_s  = wr_en_s & (~full_s | rd_en_s);
    wr_drop_s = wr_en_s & ~wr_acc_s;
    rd_nxt_s  = rd_en_s  ? (rd_ptr_r + (AW+1)'(1)) : rd_ptr_r;
    wr_nxt_s  = wr_acc_s ? (wr_ptr_r + (AW+1)'(1)) : wr_ptr_r;
    if (wr_nxt_s == rd_nxt_s) begin
      m_tdata_nxt_s = 64'h0;
    end else if (wr_ptr_r == rd_nxt_s) begin
      m_tdata_nxt_s = wr_data_s;
    end else begin
      m_tdata_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
    end
  end

  // Saturating loss counter and sticky overflow flag, cleared on RUN entry.
  always_comb begin
    drop_inc_s = {1'b0, mark_drop_s} + {1'b0, wr_drop_s};
    drop_sum_s = {1'b0, drop_cnt_r} + 33'(drop_inc_s);
    if (enter_run_s) begin
      drop_nxt_s     = 32'h0;
      overflow_nxt_s = 1'b0;
    end else if (drop_sum_s[32]) begin
      drop_nxt_s     = 32'hFFFF_FFFF;
      overflow_nxt_s = 1'b1;
    end else begin
      drop_nxt_s     = drop_sum_s[31:0];
      overflow_nxt_s = overflow_r | (drop_inc_s != 2'd0);
    end
  end

  // Control, pointer and output registers.
  always_ff @(posedge tdc_refclck or negedge tdc_rstn) begin
    if (!tdc_rstn) begin
      state_r    <= IDLE;
      pps_d_r    <= 1'b0;
      pps_cnt_r  <= {FINE_W{1'b0}};
      mark_r     <= 64'h0;
      pend_r     <= 1'b0;
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      m_tdata_r  <= 64'h0;
      m_tvalid_r <= 1'b0;
      fill_r     <= {(AW+1){1'b0}};
      drop_cnt_r <= 32'h0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pps_d_r    <= pps_trigger;
      pps_cnt_r  <= pps_cnt_nxt_s;
      mark_r     <= mark_nxt_s;
      pend_r     <= pend_nxt_s;
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      m_tdata_r  <= m_tdata_nxt_s;
      m_tvalid_r <= (wr_nxt_s != rd_nxt_s);
      fill_r     <= wr_nxt_s - rd_nxt_s;
      drop_cnt_r <= drop_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // FIFO storage; contents are only read once written, so no reset needed.
  always_ff @(posedge tdc_refclck) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
    end
  end

  assign m_tdata  = m_tdata_r;
  assign m_tvalid = m_tvalid_r;
  assign fill     = fill_r;
  assign drop_cnt = drop_cnt_r;
  assign overflow = overflow_r;

endmodule
